// File: rtl/fetch_queue.sv
// Instruction fetch unit with a small in-order queue between imem and decode.
// Define FETCH_BYPASS_EN to let a response skip an empty queue combinationally.
module fetch_queue #(
   parameter int PC_W  = 9,
   parameter int INS_W = 32,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1),
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             redirect,
   input  logic [PC_W-1:0]  redirect_pc,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic [INS_W-1:0] imem_rdata,
   input  logic             id_ready,
   output logic             if_valid,
   output logic [PC_W-1:0]  if_pc,
   output logic [INS_W-1:0] if_instr,
   output logic [CW-1:0]    fq_count
);

   logic [PC_W-1:0]  fetch_pc;
   logic [PC_W-1:0]  rsp_pc;
   logic             inflight;
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [PC_W-1:0]  pc_mem  [DEPTH];
   logic [INS_W-1:0] ins_mem [DEPTH];
   logic [CW:0]      pending;
   logic             push;
   logic             pop;
   logic             unused_bits;

   assign unused_bits = ^redirect_pc[1:0];

   // Occupancy plus the outstanding response bounds issue, so a push never meets a full queue.
   assign pending   = {1'b0, fq_count} + {{CW{1'b0}}, inflight};
   assign imem_req  = reset && !redirect && (pending < (CW+1)'(DEPTH));
   assign imem_addr = fetch_pc;

`ifdef FETCH_BYPASS_EN
   logic bypass;
   assign bypass   = (fq_count == '0) && inflight && !redirect;
   assign if_valid = !redirect && ((fq_count != '0) || bypass);
   assign push     = inflight && !redirect && !(bypass && id_ready);
`else
   assign if_valid = !redirect && (fq_count != '0);
   assign push     = inflight && !redirect;
`endif
   assign pop = !redirect && (fq_count != '0) && id_ready;

   always_comb begin
      if_pc    = '0;
      if_instr = '0;
`ifdef FETCH_BYPASS_EN
      if (bypass) begin
         if_pc    = rsp_pc;
         if_instr = imem_rdata;
      end else if (if_valid) begin
         if_pc    = pc_mem[head];
         if_instr = ins_mem[head];
      end
`else
      if (if_valid) begin
         if_pc    = pc_mem[head];
         if_instr = ins_mem[head];
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc <= '0;
         rsp_pc   <= '0;
         inflight <= 1'b0;
         head     <= '0;
         tail     <= '0;
         fq_count <= '0;
      end else if (redirect) begin
         fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
         inflight <= 1'b0;
         head     <= '0;
         tail     <= '0;
         fq_count <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            rsp_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + PC_W'(4);
         end
         if (push)
            tail <= tail + PW'(1);
         if (pop)
            head <= head + PW'(1);
         case ({push, pop})
            2'b10:   fq_count <= fq_count + CW'(1);
            2'b01:   fq_count <= fq_count - CW'(1);
            default: fq_count <= fq_count;
         endcase
      end
   end

   // Storage is left unreset; the read side is gated by if_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[tail]  <= rsp_pc;
         ins_mem[tail] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;

   localparam int PC_W  = 9;
   localparam int INS_W = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int VW    = 1 + PC_W + INS_W + CW + 1 + PC_W;
`ifdef FETCH_BYPASS_EN
   localparam int FIRST_VALID = 1;
`else
   localparam int FIRST_VALID = 2;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             redirect = 1'b0;
   logic [PC_W-1:0]  redirect_pc = '0;
   logic             imem_req;
   logic [PC_W-1:0]  imem_addr;
   logic [INS_W-1:0] imem_rdata;
   logic             id_ready = 1'b0;
   logic             if_valid;
   logic [PC_W-1:0]  if_pc;
   logic [INS_W-1:0] if_instr;
   logic [CW-1:0]    fq_count;
   logic [PC_W-1:0]  mem_addr_q = '0;

   int checks = 0;
   int fails  = 0;

   int  m_fetch;
   int  m_rsp;
   bit  m_inflight;
   int  mq[$];
   bit  m_byp;
   bit  exp_valid;
   bit  exp_req;
   int  exp_pc;
   logic [VW-1:0] exp_vec;

   fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .id_ready(id_ready), .if_valid(if_valid), .if_pc(if_pc),
      .if_instr(if_instr), .fq_count(fq_count)
   );

   always #5 clk = ~clk;

   // Instruction memory: one-cycle read latency, word content derived from its address.
   function automatic logic [INS_W-1:0] ins_of(input logic [PC_W-1:0] pc);
      return 32'hC0DE_0000 | (32'(pc) * 32'd7);
   endfunction

   assign imem_rdata = ins_of(mem_addr_q);
   always @(posedge clk) if (imem_req) mem_addr_q <= imem_addr;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout need finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [VW-1:0] observed();
      return {if_valid, if_pc, if_instr, fq_count, imem_req, imem_req ? imem_addr : PC_W'(0)};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_fetch    = 0;
      m_rsp      = 0;
      m_inflight = 0;
   endtask

   task automatic model_expect();
      m_byp = 0;
`ifdef FETCH_BYPASS_EN
      m_byp = (mq.size() == 0) && m_inflight && !redirect;
`endif
      exp_req   = !redirect && ((mq.size() + int'(m_inflight)) < DEPTH);
      exp_valid = !redirect && ((mq.size() != 0) || m_byp);
      exp_pc    = !exp_valid ? 0 : ((mq.size() != 0) ? mq[0] : m_rsp);
      exp_vec   = {exp_valid, PC_W'(exp_pc), exp_valid ? ins_of(PC_W'(exp_pc)) : INS_W'(0),
                   CW'(mq.size()), exp_req, exp_req ? PC_W'(m_fetch) : PC_W'(0)};
   endtask

   task automatic model_update();
      if (redirect) begin
         mq.delete();
         m_inflight = 0;
         m_fetch    = int'(redirect_pc) & ~3;
      end else begin
         if (exp_valid && id_ready && mq.size() != 0) void'(mq.pop_front());
         if (m_inflight && !(m_byp && id_ready)) mq.push_back(m_rsp);
         if (exp_req) begin
            m_rsp   = m_fetch;
            m_fetch = (m_fetch + 4) % (1 << PC_W);
         end
         m_inflight = exp_req;
      end
   endtask

   task automatic drive(input logic r, input logic [PC_W-1:0] rpc, input logic rdy);
      redirect    = r;
      redirect_pc = rpc;
      id_ready    = rdy;
      #1;
      model_expect();
   endtask

   task automatic commit();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({if_valid, imem_req, if_pc, if_instr, fq_count} !== '0) begin
         fails++;
         $display("[TB] FAIL reset_outputs: got %h need 0", {if_valid, imem_req, if_pc, if_instr, fq_count});
      end
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_stream();
      int first;
      int seen[$];
      first = -1;
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, '0, 1'b1);
         checks++;
         if (observed() !== exp_vec) begin
            fails++;
            $display("[TB] FAIL stream cyc%0d: got %h need %h", i, observed(), exp_vec);
         end
         if (if_valid) begin
            if (first < 0) first = i;
            seen.push_back(int'(if_pc));
         end
         commit();
      end
      checks++;
      if (first !== FIRST_VALID) begin
         fails++;
         $display("[TB] FAIL stream_first_valid: got cycle %0d need %0d", first, FIRST_VALID);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (seen.size() <= k || seen[k] !== 4 * k) begin
            fails++;
            $display("[TB] FAIL stream_pc%0d: got %0d need %0d", k, (seen.size() > k) ? seen[k] : -1, 4 * k);
         end
      end
   endtask

   task automatic test_backpressure();
      int seen[$];
      drive(1'b1, '0, 1'b0);
      commit();
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, '0, 1'b0);
         checks++;
         if (observed() !== exp_vec) begin
            fails++;
            $display("[TB] FAIL stall cyc%0d: got %h need %h", i, observed(), exp_vec);
         end
         commit();
      end
      drive(1'b0, '0, 1'b0);
      checks++;
      if (fq_count !== CW'(DEPTH) || imem_req !== 1'b0 || if_pc !== '0 || if_valid !== 1'b1) begin
         fails++;
         $display("[TB] FAIL stall_saturate: got count=%0d req=%b pc=%h need count=%0d req=0 pc=0",
                  fq_count, imem_req, if_pc, DEPTH);
      end
      commit();
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, '0, 1'b1);
         checks++;
         if (observed() !== exp_vec) begin
            fails++;
            $display("[TB] FAIL release cyc%0d: got %h need %h", i, observed(), exp_vec);
         end
         if (if_valid) seen.push_back(int'(if_pc));
         commit();
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (seen.size() <= k || seen[k] !== 4 * k) begin
            fails++;
            $display("[TB] FAIL release_pc%0d: got %0d need %0d", k, (seen.size() > k) ? seen[k] : -1, 4 * k);
         end
      end
   endtask

   task automatic test_redirect();
      int guard;
      int k;
      drive(1'b1, '0, 1'b0);
      commit();
      guard = 0;
      while (!(mq.size() == 3 && m_inflight) && guard < 20) begin
         drive(1'b0, '0, 1'b0);
         commit();
         guard++;
      end
      checks++;
      if (guard >= 20) begin
         fails++;
         $display("[TB] FAIL redirect_setup: got no count=3 state need count=3 inflight");
      end
      drive(1'b1, PC_W'(9'h040), 1'b1);
      checks++;
      if (observed() !== exp_vec) begin
         fails++;
         $display("[TB] FAIL redirect_cycle: got %h need %h", observed(), exp_vec);
      end
      commit();
      drive(1'b0, '0, 1'b1);
      checks++;
      if (fq_count !== '0 || imem_req !== 1'b1 || imem_addr !== PC_W'(9'h040)) begin
         fails++;
         $display("[TB] FAIL redirect_after: got count=%0d req=%b addr=%h need 0/1/040", fq_count, imem_req, imem_addr);
      end
      k = 0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) drive(1'b0, '0, 1'b1);
         if (if_valid) begin
            checks++;
            if (if_pc !== PC_W'(9'h040 + 4 * k)) begin
               fails++;
               $display("[TB] FAIL redirect_seq%0d: got %h need %h", k, if_pc, PC_W'(9'h040 + 4 * k));
            end
            k++;
         end
         commit();
      end
   endtask

   task automatic test_wrap();
      int seen[$];
      int need[3] = '{9'h1F8, 9'h1FC, 9'h000};
      drive(1'b1, PC_W'(9'h1F8), 1'b1);
      commit();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, '0, 1'b1);
         checks++;
         if (observed() !== exp_vec) begin
            fails++;
            $display("[TB] FAIL wrap cyc%0d: got %h need %h", i, observed(), exp_vec);
         end
         if (if_valid) seen.push_back(int'(if_pc));
         commit();
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (seen.size() <= k || seen[k] !== need[k]) begin
            fails++;
            $display("[TB] FAIL wrap_pc%0d: got %0h need %0h", k, (seen.size() > k) ? seen[k] : -1, need[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int first;
      bit stale;
      first = -1;
      stale = 0;
      drive(1'b1, PC_W'(9'h020), 1'b1);
      commit();
      drive(1'b1, PC_W'(9'h080), 1'b1);
      commit();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, '0, 1'b1);
         if (if_valid) begin
            if (first < 0) first = int'(if_pc);
            if (if_pc == PC_W'(9'h020)) stale = 1;
         end
         commit();
      end
      checks++;
      if (first !== 9'h080 || stale) begin
         fails++;
         $display("[TB] FAIL back_to_back: got first=%0h stale=%0d need first=80 stale=0", first, stale);
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      drive(1'b1, '0, 1'b0);
      commit();
      guard = 0;
      while (mq.size() != 2 && guard < 20) begin
         drive(1'b0, '0, 1'b0);
         commit();
         guard++;
      end
      checks++;
      if (fq_count !== CW'(2)) begin
         fails++;
         $display("[TB] FAIL reset_mid_setup: got count=%0d need 2", fq_count);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({if_valid, imem_req, if_pc, if_instr, fq_count} !== '0) begin
         fails++;
         $display("[TB] FAIL reset_mid_outputs: got %h need 0", {if_valid, imem_req, if_pc, if_instr, fq_count});
      end
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, '0, 1'b1);
         checks++;
         if (observed() !== exp_vec) begin
            fails++;
            $display("[TB] FAIL reset_mid_restart cyc%0d: got %h need %h", i, observed(), exp_vec);
         end
         commit();
      end
   endtask

   task automatic test_random();
      logic r;
      logic rdy;
      logic [PC_W-1:0] rpc;
      for (int i = 0; i < 400; i++) begin
         r   = ($urandom_range(0, 15) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         rpc = PC_W'($urandom);
         drive(r, rpc, rdy);
         checks++;
         if (observed() !== exp_vec) begin
            fails++;
            $display("[TB] FAIL random cyc%0d: got %h need %h", i, observed(), exp_vec);
         end
         commit();
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
